// File: rtl/return_address_stack.sv
// Speculative return address stack with a checkpoint FIFO for mispredict recovery.
// Optional build macro RAS_OCCUPANCY_TRACK_EN adds an occupancy counter that drives valid.
module return_address_stack #(
    parameter int DEPTH       = 8,
    parameter int CHECKPOINTS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_addr,
    output logic [31:0] addr,
    output logic        valid,
    input  logic        branch_fetched,
    input  logic        branch_retired,
    input  logic        early_branch_flush,
    output logic        checkpoint_full
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(CHECKPOINTS);

    typedef struct packed {
`ifdef RAS_OCCUPANCY_TRACK_EN
        logic [IW:0]   occ;
`endif
        logic [IW-1:0] idx;
    } cp_t;

    logic [DEPTH-1:0][31:0] stack;
    logic [IW-1:0]          read_index, read_index_nxt, wr_index;
    cp_t                    cp_mem [CHECKPOINTS];
    cp_t                    cp_cur, cp_head;
    logic [CW-1:0]          wr_ptr, rd_ptr;
    logic [CW:0]            count;
    logic                   fifo_empty, do_push, enq, deq;

    // A flush squashes every other request in its cycle.
    assign do_push         = push & ~early_branch_flush;
    assign fifo_empty      = (count == '0);
    assign checkpoint_full = (count == (CW+1)'(CHECKPOINTS));
    assign enq = branch_fetched & ~early_branch_flush & (~checkpoint_full | branch_retired);
    assign deq = branch_retired & ~early_branch_flush & (~fifo_empty | branch_fetched);
    assign cp_head = cp_mem[rd_ptr];
    assign addr    = stack[read_index];

    always_comb begin
        read_index_nxt = read_index;
        wr_index       = pop ? read_index : read_index + IW'(1);
        if (early_branch_flush) begin
            if (!fifo_empty) read_index_nxt = cp_head.idx;
        end else if (push && !pop) begin
            read_index_nxt = read_index + IW'(1);
        end else if (pop && !push) begin
            read_index_nxt = read_index - IW'(1);
        end
    end

`ifdef RAS_OCCUPANCY_TRACK_EN
    logic [IW:0] occ, occ_nxt;

    always_comb begin
        occ_nxt = occ;
        if (early_branch_flush) begin
            if (!fifo_empty) occ_nxt = cp_head.occ;
        end else if (push && !pop) begin
            if (occ != (IW+1)'(DEPTH)) occ_nxt = occ + (IW+1)'(1);
        end else if (pop && !push) begin
            if (occ != '0) occ_nxt = occ - (IW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) occ <= '0;
        else      occ <= occ_nxt;
    end

    assign cp_cur.occ = occ;
    assign valid      = (occ != '0);
`else
    assign valid = 1'b1;
`endif
    assign cp_cur.idx = read_index;

    // Storage arrays carry no reset.
    always_ff @(posedge clk) begin
        if (do_push) stack[wr_index] <= push_addr;
        if (enq)     cp_mem[wr_ptr]  <= cp_cur;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_index <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            read_index <= read_index_nxt;
            if (early_branch_flush) begin
                rd_ptr <= wr_ptr;
                count  <= '0;
            end else begin
                if (enq) wr_ptr <= wr_ptr + CW'(1);
                if (deq) rd_ptr <= rd_ptr + CW'(1);
                if (enq && !deq)      count <= count + (CW+1)'(1);
                else if (deq && !enq) count <= count - (CW+1)'(1);
            end
        end
    end

    // Fetch must respect checkpoint_full; an overrun is dropped.
    a_cp_overrun: assert property (@(posedge clk) disable iff (!rst)
        !(branch_fetched && !branch_retired && !early_branch_flush && checkpoint_full))
        else $warning("return_address_stack: branch_fetched while checkpoint FIFO full, dropped");

endmodule

// File: tb/tb_return_address_stack.sv
// Directed bench for return_address_stack: push/pop, wrap, checkpoints, flush, async reset.
module tb_return_address_stack;
`ifdef RAS_OCCUPANCY_TRACK_EN
    localparam bit OCC = 1'b1;
`else
    localparam bit OCC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        push = 1'b0, pop = 1'b0;
    logic [31:0] push_addr = '0;
    logic [31:0] addr;
    logic        valid;
    logic        branch_fetched = 1'b0, branch_retired = 1'b0, early_branch_flush = 1'b0;
    logic        checkpoint_full;
    int          n_tests = 0;
    int          n_fail  = 0;

    return_address_stack #(.DEPTH(8), .CHECKPOINTS(4)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .push_addr(push_addr),
        .addr(addr), .valid(valid), .branch_fetched(branch_fetched),
        .branch_retired(branch_retired), .early_branch_flush(early_branch_flush),
        .checkpoint_full(checkpoint_full)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0;
        branch_fetched = 1'b0; branch_retired = 1'b0; early_branch_flush = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        n_tests++;
        if (checkpoint_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", checkpoint_full); end
        n_tests++;
        if (valid !== !OCC) begin n_fail++; $display("FAIL reset_valid got %b exp %b", valid, !OCC); end
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] vals [3];
        vals = '{32'h100, 32'h200, 32'h300};
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; push_addr = vals[i];
            tick();
        end
        n_tests++;
        if (addr !== 32'h300 || valid !== 1'b1) begin n_fail++; $display("FAIL basic_push got %h/%b exp 300/1", addr, valid); end
        pop = 1'b1; tick();
        n_tests++;
        if (addr !== 32'h200 || valid !== 1'b1) begin n_fail++; $display("FAIL basic_pop1 got %h/%b exp 200/1", addr, valid); end
        pop = 1'b1; tick();
        n_tests++;
        if (addr !== 32'h100 || valid !== 1'b1) begin n_fail++; $display("FAIL basic_pop2 got %h/%b exp 100/1", addr, valid); end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_a;
        logic        exp_v;
        do_reset();
        // Nine pushes into eight entries: the ninth lands on the first one's slot.
        for (int k = 0; k < 9; k++) begin
            push = 1'b1; push_addr = 32'h1004 + 32'(4 * k);
            tick();
        end
        n_tests++;
        if (addr !== 32'h1024) begin n_fail++; $display("FAIL ovf_top got %h exp 1024", addr); end
        for (int i = 1; i <= 8; i++) begin
            pop = 1'b1; tick();
            exp_a = (i == 8) ? 32'h1024 : 32'h1024 - 32'(4 * i);
            exp_v = OCC ? (i < 8) : 1'b1;
            n_tests++;
            if (addr !== exp_a || valid !== exp_v) begin
                n_fail++; $display("FAIL ovf_pop%0d got %h/%b exp %h/%b", i, addr, valid, exp_a, exp_v);
            end
        end
    endtask

    task automatic test_push_pop();
        do_reset();
        push = 1'b1; push_addr = 32'h3F0; tick();
        push = 1'b1; push_addr = 32'h400; tick();
        push = 1'b1; pop = 1'b1; push_addr = 32'h500; tick();
        n_tests++;
        if (addr !== 32'h500) begin n_fail++; $display("FAIL pushpop_top got %h exp 500", addr); end
        pop = 1'b1; tick();
        n_tests++;
        if (addr !== 32'h3F0 || valid !== 1'b1) begin n_fail++; $display("FAIL pushpop_below got %h/%b exp 3f0/1", addr, valid); end
    endtask

    task automatic test_flush();
        push = 1'b1; push_addr = 32'hA0; tick();
        branch_fetched = 1'b1; tick();
        push = 1'b1; push_addr = 32'hB0; tick();
        push = 1'b1; push_addr = 32'hC0; tick();
        n_tests++;
        if (addr !== 32'hC0) begin n_fail++; $display("FAIL flush_pre got %h exp c0", addr); end
        early_branch_flush = 1'b1; tick();
        n_tests++;
        if (addr !== 32'hA0 || checkpoint_full !== 1'b0) begin
            n_fail++; $display("FAIL flush_restore got %h/%b exp a0/0", addr, checkpoint_full);
        end
        // Empty FIFO: flush leaves the pointer, and the concurrent push is squashed.
        early_branch_flush = 1'b1; push = 1'b1; push_addr = 32'hEE; tick();
        n_tests++;
        if (addr !== 32'hA0) begin n_fail++; $display("FAIL flush_empty got %h exp a0", addr); end
        // Checkpoint taken alongside a push records the pre-push pointer.
        push = 1'b1; branch_fetched = 1'b1; push_addr = 32'hD0; tick();
        n_tests++;
        if (addr !== 32'hD0) begin n_fail++; $display("FAIL flush_d0 got %h exp d0", addr); end
        push = 1'b1; push_addr = 32'hE0; tick();
        early_branch_flush = 1'b1; tick();
        n_tests++;
        if (addr !== 32'hA0) begin n_fail++; $display("FAIL flush_prepush got %h exp a0", addr); end
    endtask

    task automatic test_checkpoint_full();
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (checkpoint_full !== 1'b0) begin n_fail++; $display("FAIL cp_fill%0d got %b exp 0", i, checkpoint_full); end
            branch_fetched = 1'b1; push = 1'b1; push_addr = 32'h11 + 32'(i); tick();
        end
        n_tests++;
        if (checkpoint_full !== 1'b1) begin n_fail++; $display("FAIL cp_full got %b exp 1", checkpoint_full); end
        branch_fetched = 1'b1; branch_retired = 1'b1; push = 1'b1; push_addr = 32'h15; tick();
        n_tests++;
        if (checkpoint_full !== 1'b1) begin n_fail++; $display("FAIL cp_swap got %b exp 1", checkpoint_full); end
        branch_fetched = 1'b1; push = 1'b1; push_addr = 32'h16; tick();
        n_tests++;
        if (checkpoint_full !== 1'b1 || addr !== 32'h16) begin
            n_fail++; $display("FAIL cp_overrun got %b/%h exp 1/16", checkpoint_full, addr);
        end
        branch_retired = 1'b1; tick();
        n_tests++;
        if (checkpoint_full !== 1'b0) begin n_fail++; $display("FAIL cp_retire got %b exp 0", checkpoint_full); end
        // Oldest remaining checkpoint is the pointer captured before pushing 0x13.
        early_branch_flush = 1'b1; tick();
        n_tests++;
        if (addr !== 32'h12 || checkpoint_full !== 1'b0) begin
            n_fail++; $display("FAIL cp_flush got %h/%b exp 12/0", addr, checkpoint_full);
        end
    endtask

    task automatic test_async_reset();
        branch_fetched = 1'b1; tick();
        branch_fetched = 1'b1; tick();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        n_tests++;
        if (checkpoint_full !== 1'b0) begin n_fail++; $display("FAIL areset_full got %b exp 0", checkpoint_full); end
        n_tests++;
        if (valid !== !OCC) begin n_fail++; $display("FAIL areset_valid got %b exp %b", valid, !OCC); end
        n_tests++;
        if (addr !== 32'h16) begin n_fail++; $display("FAIL areset_index got %h exp 16", addr); end
        tick();
        rst = 1'b1;
        early_branch_flush = 1'b1; tick();
        n_tests++;
        if (addr !== 32'h16) begin n_fail++; $display("FAIL areset_fifo_empty got %h exp 16", addr); end
        for (int i = 0; i < 3; i++) begin
            branch_fetched = 1'b1; tick();
        end
        n_tests++;
        if (checkpoint_full !== 1'b0) begin n_fail++; $display("FAIL areset_count3 got %b exp 0", checkpoint_full); end
        branch_fetched = 1'b1; tick();
        n_tests++;
        if (checkpoint_full !== 1'b1) begin n_fail++; $display("FAIL areset_count4 got %b exp 1", checkpoint_full); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_push_pop();
        test_flush();
        test_checkpoint_full();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
